// File: rtl/rect_fill_writer.sv
// Fills a clipped screen rectangle of the colour-index frame buffer with one index, one write per clock.
// Latency: start sampled at edge N -> busy from N+1, first write at N+2, done at N+2+W*H (plus stall cycles).
// Backpressure: fb_wait holds the presented write (address, data, strobe) and freezes the raster counters.
//
// Ports:
//   iVGA_CLK, iRST                  clock, asynchronous active-high reset
//   start                           request pulse, only honoured in IDLE
//   rect_x/rect_y/rect_w/rect_h     rectangle origin and size (latched on start)
//   color_idx                       fill colour index (latched on start)
//   fb_wait                         frame-buffer write port busy
//   busy, done                      operation in progress / one-cycle completion pulse
//   fb_wr_en, fb_addr, fb_data      frame-buffer write port (address = y*H_ACTIVE + x)
module rect_fill_writer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 8
) (
   input  logic              iVGA_CLK,
   input  logic              iRST,
   input  logic              start,
   input  logic [9:0]        rect_x,
   input  logic [8:0]        rect_y,
   input  logic [9:0]        rect_w,
   input  logic [8:0]        rect_h,
   input  logic [DATA_W-1:0] color_idx,
   input  logic              fb_wait,
   output logic              busy,
   output logic              done,
   output logic              fb_wr_en,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLIP,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [10:0]       H_LIM    = 11'(H_ACTIVE);
   localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t state;

   // Request captured at start; later input changes are ignored.
   logic [9:0]        rectX;
   logic [8:0]        rectY;
   logic [9:0]        rectW;
   logic [8:0]        rectH;
   logic [DATA_W-1:0] colorLat;

   // Raster position of the write currently presented on the port.
   logic [9:0]        xCur;
   logic [8:0]        yCur;
   logic [10:0]       xLast;     // last column written (inclusive, already clipped)
   logic [9:0]        yLast;     // last row written (inclusive, already clipped)
   logic [ADDR_W-1:0] rowBase;   // yCur * H_ACTIVE, advanced by addition each row

   // Clip arithmetic, evaluated from the latched request during CLIP.
   // Sums are one bit wider than the operands so they cannot wrap before the min().
   logic [10:0]       xSum;
   logic [10:0]       xEndC;
   logic [9:0]        ySum;
   logic [9:0]        yEndC;
   logic              isEmpty;
   logic [ADDR_W-1:0] rowBaseC;

   always_comb begin
      xSum     = {1'b0, rectX} + {1'b0, rectW};
      ySum     = {1'b0, rectY} + {1'b0, rectH};
      xEndC    = (xSum > H_LIM) ? H_LIM : xSum;
      yEndC    = (ySum > V_LIM) ? V_LIM : ySum;
      isEmpty  = ({1'b0, rectX} >= H_LIM) || ({1'b0, rectY} >= V_LIM) ||
                 (rectW == 10'd0) || (rectH == 9'd0);
      // Constant-coefficient product, used once per operation to seed the row base;
      // the fill loop itself only ever adds ROW_STEP.
      rowBaseC = ADDR_W'(rectY) * ROW_STEP;
   end

   logic lastCol;
   logic lastRow;
   assign lastCol = ({1'b0, xCur} == xLast);
   assign lastRow = ({1'b0, yCur} == yLast);

   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         fb_wr_en <= 1'b0;
         fb_addr  <= '0;
         fb_data  <= '0;
         rectX    <= '0;
         rectY    <= '0;
         rectW    <= '0;
         rectH    <= '0;
         colorLat <= '0;
         xCur     <= '0;
         yCur     <= '0;
         xLast    <= '0;
         yLast    <= '0;
         rowBase  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rectX    <= rect_x;
                  rectY    <= rect_y;
                  rectW    <= rect_w;
                  rectH    <= rect_h;
                  colorLat <= color_idx;
                  busy     <= 1'b1;
                  state    <= S_CLIP;
               end
            end

            S_CLIP: begin
               if (isEmpty) begin
                  // Nothing visible: complete without touching the write port.
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  xCur     <= rectX;
                  yCur     <= rectY;
                  xLast    <= xEndC - 11'd1;
                  yLast    <= yEndC - 10'd1;
                  rowBase  <= rowBaseC;
                  fb_addr  <= rowBaseC + ADDR_W'(rectX);
                  fb_data  <= colorLat;
                  fb_wr_en <= 1'b1;
                  state    <= S_FILL;
               end
            end

            S_FILL: begin
               // A write retires only when the port is free; otherwise everything holds.
               if (!fb_wait) begin
                  if (lastCol && lastRow) begin
                     fb_wr_en <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end else if (lastCol) begin
                     xCur    <= rectX;
                     yCur    <= yCur + 9'd1;
                     rowBase <= rowBase + ROW_STEP;
                     fb_addr <= rowBase + ROW_STEP + ADDR_W'(rectX);
                  end else begin
                     xCur    <= xCur + 10'd1;
                     fb_addr <= fb_addr + ADDR_ONE;
                  end
               end
            end

            S_DONE: begin
               // A start arriving here is dropped; the next IDLE cycle accepts one.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_fill_writer.sv
module tb_rect_fill_writer;

   localparam int HA = 640;
   localparam int VA = 480;

   logic        iVGA_CLK = 1'b0;
   logic        iRST = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  rect_x = '0;
   logic [8:0]  rect_y = '0;
   logic [9:0]  rect_w = '0;
   logic [8:0]  rect_h = '0;
   logic [7:0]  color_idx = '0;
   logic        fb_wait = 1'b0;
   logic        busy;
   logic        done;
   logic        fb_wr_en;
   logic [18:0] fb_addr;
   logic [7:0]  fb_data;

   rect_fill_writer #(
      .H_ACTIVE(HA),
      .V_ACTIVE(VA),
      .ADDR_W(19),
      .DATA_W(8)
   ) dut (
      .iVGA_CLK (iVGA_CLK),
      .iRST     (iRST),
      .start    (start),
      .rect_x   (rect_x),
      .rect_y   (rect_y),
      .rect_w   (rect_w),
      .rect_h   (rect_h),
      .color_idx(color_idx),
      .fb_wait  (fb_wait),
      .busy     (busy),
      .done     (done),
      .fb_wr_en (fb_wr_en),
      .fb_addr  (fb_addr),
      .fb_data  (fb_data)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   int nTests = 0;
   int nFail  = 0;
   int lastDoneRel;
   int lastStalls;

   // Optional back-to-back request, driven on the first IDLE cycle after a done.
   bit chainOn = 1'b0;
   int chX, chY, chW, chH, chIdx;

   task automatic check(input string tag, input longint got, input longint exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issues one request (unless already on the pins) and checks the write stream
   // against a list of visible pixels built from the clip rules.
   task automatic run_op(input int x, input int y, input int w, input int h, input int idx,
                         input bit randStall, input int stallAddr, input int stallLen,
                         input bit hammer, input bit preStarted, input string tag);
      int expA[$];
      int gotA[$];
      int gotD[$];
      int firstRel, doneRel, stalls, wrCycles, busyBad, heldBad, prevAddr, stallLeft, n;
      bit prevStall, finished;

      for (int yy = y; yy < VA && yy < y + h; yy++)
         for (int xx = x; xx < HA && xx < x + w; xx++)
            expA.push_back(yy * HA + xx);
      n = expA.size();

      if (!preStarted) begin
         @(posedge iVGA_CLK); #1;
         start = 1'b1; rect_x = 10'(x); rect_y = 9'(y); rect_w = 10'(w); rect_h = 9'(h);
         color_idx = 8'(idx); fb_wait = 1'b0;
      end
      @(posedge iVGA_CLK); #1;   // edge N has sampled the request
      start = 1'b0;
      rect_x = 10'($urandom); rect_y = 9'($urandom); rect_w = 10'($urandom);
      rect_h = 9'($urandom); color_idx = 8'($urandom);

      firstRel = -1; doneRel = -1; stalls = 0; wrCycles = 0; busyBad = 0; heldBad = 0;
      prevAddr = 0; prevStall = 1'b0; finished = 1'b0; stallLeft = stallLen;
      for (int rel = 1; rel <= 4000 && !finished; rel++) begin
         @(negedge iVGA_CLK);
         if (!busy) busyBad++;
         if (prevStall && (fb_addr !== 19'(prevAddr) || !fb_wr_en)) heldBad++;
         if (fb_wr_en) begin
            wrCycles++;
            if (firstRel < 0) firstRel = rel;
            if (fb_wait) stalls++;
            else begin
               gotA.push_back(int'(fb_addr));
               gotD.push_back(int'(fb_data));
            end
            prevStall = fb_wait;
            prevAddr  = int'(fb_addr);
         end else begin
            prevStall = 1'b0;
         end
         if (done) begin
            doneRel  = rel;
            finished = 1'b1;
         end else begin
            @(posedge iVGA_CLK); #1;
            fb_wait = randStall ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (stallLen > 0 && fb_wr_en && int'(fb_addr) == stallAddr && stallLeft > 0) begin
               fb_wait = 1'b1;
               stallLeft--;
            end
            // Pulses landing while busy, including the done cycle itself, must be dropped.
            start = hammer ? (done ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
         end
      end
      if (!finished) check({tag, "_timeout"}, 1, 0);

      check({tag, "_nwr"}, gotA.size(), n);
      for (int i = 0; i < n && i < gotA.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), gotA[i], expA[i]);
         check($sformatf("%s_data%0d", tag, i), gotD[i], idx & 255);
      end
      check({tag, "_busy"}, busyBad, 0);
      check({tag, "_held"}, heldBad, 0);
      if (n == 0) begin
         check({tag, "_nowr"}, firstRel, -1);
         check({tag, "_donerel"}, doneRel, 2);
      end else begin
         check({tag, "_firstrel"}, firstRel, 2);
         check({tag, "_wrcyc"}, wrCycles, n + stalls);
         check({tag, "_donerel"}, doneRel, 2 + n + stalls);
      end
      lastDoneRel = doneRel;
      lastStalls  = stalls;

      @(posedge iVGA_CLK); #1;
      fb_wait = 1'b0;
      if (chainOn) begin
         start = 1'b1; rect_x = 10'(chX); rect_y = 9'(chY); rect_w = 10'(chW);
         rect_h = 9'(chH); color_idx = 8'(chIdx);
         chainOn = 1'b0;
      end else begin
         start = 1'b0;
      end
      @(negedge iVGA_CLK);
      check({tag, "_post_busy"}, busy, 0);
      check({tag, "_post_done"}, done, 0);
      check({tag, "_post_wr"}, fb_wr_en, 0);
   endtask

   initial begin
      int wrSeen, bad, rx, ry, rw, rh;
      bit hit;

      // Reset state
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr", fb_wr_en, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      repeat (2) @(posedge iVGA_CLK);
      #1 iRST = 1'b0;

      // Basic fill
      run_op(10, 20, 4, 2, 'h3C, 0, -1, 0, 0, 0, "basic");
      check("basic_done_at", lastDoneRel, 10);

      // Right/bottom clip
      run_op(636, 478, 8, 4, 'h55, 0, -1, 0, 0, 0, "edgeclip");

      // Empty and single-row cases
      run_op(100, 100, 0, 5, 'h11, 0, -1, 0, 0, 0, "w0");
      run_op(640, 10, 5, 5, 'h22, 0, -1, 0, 0, 0, "x640");
      run_op(5, 479, 7, 1, 'h33, 0, -1, 0, 0, 0, "lastrow");
      run_op(20, 30, 4, 0, 'h44, 0, -1, 0, 0, 0, "h0");
      run_op(0, 480, 4, 4, 'h66, 0, -1, 0, 0, 0, "y480");

      // Stall on the second write for three cycles
      run_op(10, 20, 4, 2, 'h3C, 0, 12811, 3, 0, 0, "stall");
      check("stall_cycles", lastStalls, 3);
      check("stall_done_at", lastDoneRel, 13);

      // Starts during busy and on done ignored; start right after done accepted
      chainOn = 1'b1; chX = 300; chY = 200; chW = 3; chH = 3; chIdx = 'hA5;
      run_op(10, 20, 4, 2, 'h3C, 0, -1, 0, 1, 0, "hammer");
      run_op(300, 200, 3, 3, 'hA5, 0, -1, 0, 0, 1, "chained");

      // Reset in the middle of a fill
      @(posedge iVGA_CLK); #1;
      start = 1'b1; rect_x = 10; rect_y = 20; rect_w = 4; rect_h = 2; color_idx = 8'h3C;
      @(posedge iVGA_CLK); #1;
      start = 1'b0;
      wrSeen = 0; hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge iVGA_CLK);
         if (fb_wr_en) wrSeen++;
         if (wrSeen == 3) hit = 1'b1;
      end
      check("midrst_reached", hit, 1);
      check("midrst_addr3", fb_addr, 12812);
      iRST = 1'b1;
      #1;
      check("midrst_wr", fb_wr_en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_addr", fb_addr, 0);
      repeat (2) @(posedge iVGA_CLK);
      #1 iRST = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge iVGA_CLK);
         if (fb_wr_en || busy || done) bad++;
      end
      check("midrst_quiet", bad, 0);
      run_op(10, 20, 4, 2, 'h3C, 0, -1, 0, 0, 0, "afterrst");

      // Randomised rectangles, biased toward screen edges, with random stalls and start pulses
      for (int t = 0; t < 25; t++) begin
         rx = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 700) : $urandom_range(0, 639);
         ry = ($urandom_range(0, 1) == 1) ? $urandom_range(440, 511) : $urandom_range(0, 479);
         rw = $urandom_range(0, 24);
         rh = $urandom_range(0, 12);
         run_op(rx, ry, rw, rh, $urandom_range(0, 255), 1'($urandom_range(0, 1)), -1, 0,
                1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
